// File: rtl/fetch_sequencer_if.sv
// rtl/fetch_sequencer_if.sv - fetch sequencer bus: imem fields, hazard controls, fetch outputs
//
// Purpose: groups every non-clock/reset signal of the fetch sequencer.
// Ports (modport master = sequencer side, slave = surrounding pipeline):
//   icode/ifun/valC        imem fields decoded at the current pc (into sequencer)
//   stall/redirect_en/_pc  hazard and branch-resolution controls (into sequencer)
//   pc, f_valP, f_pred_pc  fetch addresses (out of sequencer)
//   f_valid, f_stat        fetch qualifier and status (out of sequencer)
//   halted, fetch_cnt      frozen indication and accepted-fetch counter
interface fetch_sequencer_if #(
    parameter int DATA_WID = 64
);
    logic [3:0]          icode;
    logic [3:0]          ifun;
    logic [DATA_WID-1:0] valC;
    logic                stall;
    logic                redirect_en;
    logic [DATA_WID-1:0] redirect_pc;
    logic [DATA_WID-1:0] pc;
    logic [DATA_WID-1:0] f_valP;
    logic [DATA_WID-1:0] f_pred_pc;
    logic                f_valid;
    logic [1:0]          f_stat;
    logic                halted;
    logic [31:0]         fetch_cnt;

    modport master (
        input  icode, ifun, valC, stall, redirect_en, redirect_pc,
        output pc, f_valP, f_pred_pc, f_valid, f_stat, halted, fetch_cnt
    );

    modport slave (
        output icode, ifun, valC, stall, redirect_en, redirect_pc,
        input  pc, f_valP, f_pred_pc, f_valid, f_stat, halted, fetch_cnt
    );
endinterface

// File: rtl/fetch_sequencer.sv
// rtl/fetch_sequencer.sv - program counter owner and next-fetch-address selection
//
// Purpose: holds pc, decodes instruction length, predicts the next pc and
// freezes fetch on HALT, bad instruction, bad address or an unresolved RET.
// Ports:
//   clk    rising-edge clock
//   rst_n  synchronous active-low reset
//   bus    fetch_sequencer_if.master (imem fields, stall/redirect, fetch outputs)
module fetch_sequencer #(
    parameter int                  DATA_WID   = 64,
    parameter int                  INS_LENGTH = 2048,
    parameter logic [DATA_WID-1:0] RESET_PC   = '0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    fetch_sequencer_if.master    bus
);

    localparam logic [1:0] STAT_AOK = 2'd0;
    localparam logic [1:0] STAT_HLT = 2'd1;
    localparam logic [1:0] STAT_ADR = 2'd2;
    localparam logic [1:0] STAT_INS = 2'd3;

    localparam logic [DATA_WID-1:0] LP_LIMIT     = DATA_WID'(INS_LENGTH);
    localparam logic [DATA_WID:0]   LP_LIMIT_EXT = (DATA_WID+1)'(INS_LENGTH);

    typedef enum logic [1:0] {
        ST_RUN,
        ST_WAIT_RET,
        ST_HALT,
        ST_ERR
    } state_t;

    state_t              r_state;
    logic [DATA_WID-1:0] r_pc;
    logic [31:0]         r_cnt;
    logic [1:0]          r_err_stat;

    logic                w_need_regids;
    logic                w_need_valc;
    logic                w_ifun_fixed;
    logic [3:0]          w_len;
    logic [DATA_WID-1:0] w_valp;
    logic [DATA_WID-1:0] w_pred;
    logic [DATA_WID:0]   w_end;
    logic                w_ins_err;
    logic                w_adr_err;
    logic [1:0]          w_run_stat;
    logic                w_accept;

    // Field-presence and fixed-ifun decode by icode.
    always_comb begin
        w_need_regids = 1'b0;
        w_need_valc   = 1'b0;
        w_ifun_fixed  = 1'b0;
        case (bus.icode)
            4'h2, 4'h6, 4'hA, 4'hB: w_need_regids = 1'b1;
            4'h3, 4'h4, 4'h5: begin
                w_need_regids = 1'b1;
                w_need_valc   = 1'b1;
            end
            4'h7, 4'h8: w_need_valc = 1'b1;
            default: ;
        endcase
        case (bus.icode)
            4'h0, 4'h1, 4'h3, 4'h4, 4'h5, 4'h8, 4'h9, 4'hA, 4'hB: w_ifun_fixed = 1'b1;
            default: ;
        endcase
    end

    assign w_len  = 4'd1 + {3'd0, w_need_regids} + {w_need_valc, 3'd0};
    assign w_valp = r_pc + DATA_WID'(w_len);
    assign w_pred = (bus.icode == 4'h7 || bus.icode == 4'h8) ? bus.valC : w_valp;

    // End address carried one bit wider so a pc near 2^DATA_WID cannot wrap
    // back into the legal range.
    assign w_end     = {1'b0, r_pc} + (DATA_WID+1)'(w_len);
    assign w_ins_err = (bus.icode > 4'hB) || (w_ifun_fixed && bus.ifun != 4'h0);
    assign w_adr_err = (r_pc >= LP_LIMIT) || (w_end > LP_LIMIT_EXT);

    always_comb begin
        w_run_stat = STAT_AOK;
        if (w_ins_err) begin
            w_run_stat = STAT_INS;
        end else if (w_adr_err) begin
            w_run_stat = STAT_ADR;
        end else if (bus.icode == 4'h0) begin
            w_run_stat = STAT_HLT;
        end
    end

    // A fetch is accepted only in RUN with neither redirect nor stall; error
    // and halt fetches are still accepted so their status flows downstream.
    assign w_accept = (r_state == ST_RUN) && !bus.redirect_en && !bus.stall;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_pc       <= RESET_PC;
            r_state    <= ST_RUN;
            r_cnt      <= '0;
            r_err_stat <= STAT_AOK;
        end else if (bus.redirect_en) begin
            r_pc       <= bus.redirect_pc;
            r_state    <= ST_RUN;
            r_err_stat <= STAT_AOK;
        end else if (w_accept) begin
            r_cnt <= r_cnt + 32'd1;
            case (w_run_stat)
                STAT_AOK: begin
                    if (bus.icode == 4'h9) begin
                        r_state <= ST_WAIT_RET;
                    end else begin
                        r_pc <= w_pred;
                    end
                end
                STAT_HLT: r_state <= ST_HALT;
                default: begin
                    r_state    <= ST_ERR;
                    r_err_stat <= w_run_stat;
                end
            endcase
        end
    end

    always_comb begin
        case (r_state)
            ST_RUN:      bus.f_stat = w_run_stat;
            ST_WAIT_RET: bus.f_stat = STAT_AOK;
            ST_HALT:     bus.f_stat = STAT_HLT;
            default:     bus.f_stat = r_err_stat;
        endcase
    end

    assign bus.pc        = r_pc;
    assign bus.f_valP    = w_valp;
    assign bus.f_pred_pc = w_pred;
    assign bus.f_valid   = w_accept;
    assign bus.halted    = (r_state == ST_HALT) || (r_state == ST_ERR);
    assign bus.fetch_cnt = r_cnt;

endmodule

// File: tb/tb_fetch_sequencer.sv
// tb/tb_fetch_sequencer.sv - self-checking bench for fetch_sequencer
module tb_fetch_sequencer;

    localparam int DW  = 64;
    localparam int LEN = 2048;

    logic clk;
    logic rst_n;

    fetch_sequencer_if #(.DATA_WID(DW)) bus ();

    fetch_sequencer #(
        .DATA_WID   (DW),
        .INS_LENGTH (LEN),
        .RESET_PC   ('0)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Reference model: mode 0=running, 1=waiting for RET target, 2=halted, 3=error.
    logic [DW-1:0] m_pc   = '0;
    logic [31:0]   m_cnt  = '0;
    int            m_mode = 0;
    int            m_err  = 0;

    logic [DW-1:0] e_valp;
    logic [DW-1:0] e_pred;
    logic          e_valid;
    logic [1:0]    e_stat;
    logic          e_halted;
    int            e_run_stat;

    function automatic void model_eval();
        int ic, len;
        ic  = int'(bus.icode);
        len = 1 + ((32'h0C7C >> ic) & 1) + 8 * ((32'h01B8 >> ic) & 1);
        e_valp = m_pc + DW'(len);
        e_pred = (ic == 7 || ic == 8) ? bus.valC : e_valp;
        if (ic > 11 || (((32'h0F3B >> ic) & 1) == 1 && bus.ifun != 0))
            e_run_stat = 3;
        else if (m_pc >= DW'(LEN) || m_pc + DW'(len) > DW'(LEN))
            e_run_stat = 2;
        else if (ic == 0)
            e_run_stat = 1;
        else
            e_run_stat = 0;
        e_valid  = (m_mode == 0) && !bus.redirect_en && !bus.stall;
        e_halted = (m_mode >= 2);
        case (m_mode)
            0:       e_stat = 2'(e_run_stat);
            1:       e_stat = 2'd0;
            2:       e_stat = 2'd1;
            default: e_stat = 2'(m_err);
        endcase
    endfunction

    function automatic void model_commit();
        if (!rst_n) begin
            m_pc = '0; m_cnt = '0; m_mode = 0; m_err = 0;
        end else if (bus.redirect_en) begin
            m_pc = bus.redirect_pc; m_mode = 0; m_err = 0;
        end else if (!bus.stall && m_mode == 0) begin
            m_cnt = m_cnt + 1;
            if (e_run_stat == 0) begin
                if (bus.icode == 4'h9) m_mode = 1;
                else m_pc = e_pred;
            end else if (e_run_stat == 1) begin
                m_mode = 2;
            end else begin
                m_mode = 3;
                m_err  = e_run_stat;
            end
        end
    endfunction

    task automatic drive(input logic [3:0] ic, input logic [3:0] fn, input logic [DW-1:0] vc,
                         input logic st, input logic re, input logic [DW-1:0] rp, input logic rn);
        bus.icode = ic; bus.ifun = fn; bus.valC = vc;
        bus.stall = st; bus.redirect_en = re; bus.redirect_pc = rp;
        rst_n = rn;
        #1;
        model_eval();
    endtask

    task automatic tick();
        @(posedge clk);
        model_commit();
        @(negedge clk);
    endtask

    task automatic goto_pc(input logic [DW-1:0] a);
        drive(4'h1, 4'h0, '0, 1'b0, 1'b1, a, 1'b1);
        tick();
    endtask

    task automatic test_reset();
        drive(4'h1, 4'h0, '0, 1'b0, 1'b0, '0, 1'b0);
        tick();
        if (bus.pc !== 64'd0) begin errors++; $display("FAIL reset_pc got=%0h exp=0", bus.pc); end
        checks++;
        if (bus.fetch_cnt !== 32'd0) begin errors++; $display("FAIL reset_cnt got=%0d exp=0", bus.fetch_cnt); end
        checks++;
        if (bus.halted !== 1'b0) begin errors++; $display("FAIL reset_halted got=%b exp=0", bus.halted); end
        checks++;
    endtask

    task automatic test_straight_line();
        drive(4'h1, 4'h0, '0, 1'b0, 1'b0, '0, 1'b1);
        if (bus.f_valid !== 1'b1) begin errors++; $display("FAIL nop_valid got=%b exp=1", bus.f_valid); end
        checks++;
        if (bus.f_valP !== 64'd1) begin errors++; $display("FAIL nop_valp got=%0h exp=1", bus.f_valP); end
        checks++;
        tick();
        if (bus.pc !== 64'd1) begin errors++; $display("FAIL seq_pc1 got=%0h exp=1", bus.pc); end
        checks++;
        drive(4'h3, 4'h0, 64'h1234, 1'b0, 1'b0, '0, 1'b1);
        if (bus.f_valP !== 64'd11) begin errors++; $display("FAIL irmov_valp got=%0h exp=b", bus.f_valP); end
        checks++;
        if (bus.f_valid !== 1'b1) begin errors++; $display("FAIL irmov_valid got=%b exp=1", bus.f_valid); end
        checks++;
        tick();
        if (bus.pc !== 64'd11) begin errors++; $display("FAIL seq_pc2 got=%0h exp=b", bus.pc); end
        checks++;
        if (bus.fetch_cnt !== 32'd2) begin errors++; $display("FAIL seq_cnt got=%0d exp=2", bus.fetch_cnt); end
        checks++;
    endtask

    task automatic test_jump();
        goto_pc(64'h20);
        drive(4'h7, 4'h0, 64'h100, 1'b0, 1'b0, '0, 1'b1);
        if (bus.f_valP !== 64'h29) begin errors++; $display("FAIL jmp_valp got=%0h exp=29", bus.f_valP); end
        checks++;
        if (bus.f_pred_pc !== 64'h100) begin errors++; $display("FAIL jmp_pred got=%0h exp=100", bus.f_pred_pc); end
        checks++;
        tick();
        if (bus.pc !== 64'h100) begin errors++; $display("FAIL jmp_pc got=%0h exp=100", bus.pc); end
        checks++;
    endtask

    task automatic test_ret();
        goto_pc(64'h40);
        drive(4'h9, 4'h0, '0, 1'b0, 1'b0, '0, 1'b1);
        if (bus.f_valid !== 1'b1) begin errors++; $display("FAIL ret_valid got=%b exp=1", bus.f_valid); end
        checks++;
        tick();
        drive(4'h1, 4'h0, '0, 1'b0, 1'b0, '0, 1'b1);
        if (bus.pc !== 64'h40) begin errors++; $display("FAIL ret_hold_pc got=%0h exp=40", bus.pc); end
        checks++;
        if (bus.f_valid !== 1'b0) begin errors++; $display("FAIL ret_wait_valid got=%b exp=0", bus.f_valid); end
        checks++;
        if (bus.f_stat !== 2'd0 || bus.halted !== 1'b0) begin
            errors++; $display("FAIL ret_wait_stat got=%0d/%b exp=0/0", bus.f_stat, bus.halted);
        end
        checks++;
        tick();
        if (bus.pc !== 64'h40) begin errors++; $display("FAIL ret_hold2_pc got=%0h exp=40", bus.pc); end
        checks++;
        goto_pc(64'h55);
        drive(4'h1, 4'h0, '0, 1'b0, 1'b0, '0, 1'b1);
        if (bus.pc !== 64'h55) begin errors++; $display("FAIL ret_target_pc got=%0h exp=55", bus.pc); end
        checks++;
        if (bus.f_valid !== 1'b1) begin errors++; $display("FAIL ret_resume_valid got=%b exp=1", bus.f_valid); end
        checks++;
    endtask

    task automatic test_stall();
        logic [31:0] cnt0;
        goto_pc(64'h8);
        cnt0 = bus.fetch_cnt;
        for (int i = 0; i < 3; i++) begin
            drive(4'h1, 4'h0, '0, 1'b1, 1'b0, '0, 1'b1);
            if (bus.f_valid !== 1'b0) begin errors++; $display("FAIL stall_valid got=%b exp=0", bus.f_valid); end
            checks++;
            tick();
        end
        if (bus.pc !== 64'h8) begin errors++; $display("FAIL stall_pc got=%0h exp=8", bus.pc); end
        checks++;
        if (bus.fetch_cnt !== cnt0) begin errors++; $display("FAIL stall_cnt got=%0d exp=%0d", bus.fetch_cnt, cnt0); end
        checks++;
        drive(4'h1, 4'h0, '0, 1'b1, 1'b1, 64'h80, 1'b1);
        tick();
        if (bus.pc !== 64'h80) begin errors++; $display("FAIL stall_redirect_pc got=%0h exp=80", bus.pc); end
        checks++;
    endtask

    task automatic test_errors();
        goto_pc(64'h10);
        drive(4'hC, 4'h0, '0, 1'b0, 1'b0, '0, 1'b1);
        if (bus.f_stat !== 2'd3) begin errors++; $display("FAIL ins_stat got=%0d exp=3", bus.f_stat); end
        checks++;
        tick();
        drive(4'h1, 4'h0, '0, 1'b0, 1'b0, '0, 1'b1);
        if (bus.halted !== 1'b1 || bus.f_stat !== 2'd3) begin
            errors++; $display("FAIL ins_latched got=%b/%0d exp=1/3", bus.halted, bus.f_stat);
        end
        checks++;
        if (bus.pc !== 64'h10) begin errors++; $display("FAIL ins_pc got=%0h exp=10", bus.pc); end
        checks++;
        goto_pc(64'd2040);
        drive(4'h3, 4'h0, 64'h5, 1'b0, 1'b0, '0, 1'b1);
        if (bus.f_stat !== 2'd2) begin errors++; $display("FAIL adr_stat got=%0d exp=2", bus.f_stat); end
        checks++;
        tick();
        drive(4'h1, 4'h0, '0, 1'b0, 1'b0, '0, 1'b1);
        if (bus.halted !== 1'b1 || bus.f_stat !== 2'd2) begin
            errors++; $display("FAIL adr_latched got=%b/%0d exp=1/2", bus.halted, bus.f_stat);
        end
        checks++;
        goto_pc(64'd0);
        drive(4'h1, 4'h0, '0, 1'b0, 1'b0, '0, 1'b1);
        if (bus.halted !== 1'b0 || bus.f_stat !== 2'd0) begin
            errors++; $display("FAIL err_cleared got=%b/%0d exp=0/0", bus.halted, bus.f_stat);
        end
        checks++;
        goto_pc(64'd2038);
        drive(4'h3, 4'h0, '0, 1'b0, 1'b0, '0, 1'b1);
        if (bus.f_stat !== 2'd0) begin errors++; $display("FAIL adr_edge_ok got=%0d exp=0", bus.f_stat); end
        checks++;
    endtask

    task automatic test_halt_reset();
        goto_pc(64'h30);
        drive(4'h0, 4'h0, '0, 1'b0, 1'b0, '0, 1'b1);
        if (bus.f_stat !== 2'd1) begin errors++; $display("FAIL hlt_stat got=%0d exp=1", bus.f_stat); end
        checks++;
        tick();
        drive(4'h1, 4'h0, '0, 1'b0, 1'b0, '0, 1'b1);
        if (bus.halted !== 1'b1 || bus.f_stat !== 2'd1) begin
            errors++; $display("FAIL hlt_state got=%b/%0d exp=1/1", bus.halted, bus.f_stat);
        end
        checks++;
        drive(4'h1, 4'h0, '0, 1'b0, 1'b1, 64'h99, 1'b0);
        tick();
        if (bus.pc !== 64'd0 || bus.fetch_cnt !== 32'd0 || bus.halted !== 1'b0) begin
            errors++; $display("FAIL hlt_reset got=%0h/%0d/%b exp=0/0/0", bus.pc, bus.fetch_cnt, bus.halted);
        end
        checks++;
    endtask

    task automatic test_random();
        logic [3:0]    ic, fn;
        logic [DW-1:0] vc, rp;
        logic          st, re, rn;
        for (int n = 0; n < 600; n++) begin
            ic = ($urandom_range(0, 9) < 8) ? 4'($urandom_range(0, 11)) : 4'($urandom_range(0, 15));
            fn = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(0, 15)) : 4'h0;
            vc = DW'($urandom_range(0, 2100));
            st = ($urandom_range(0, 5) == 0);
            re = (m_mode != 0) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 19) == 0);
            rp = DW'($urandom_range(0, 2047));
            if ($urandom_range(0, 7) == 0) rp = DW'(2035 + $urandom_range(0, 15));
            if ($urandom_range(0, 31) == 0) rp = '1 - DW'($urandom_range(0, 3));
            rn = ($urandom_range(0, 99) != 0);
            drive(ic, fn, vc, st, re, rp, rn);
            if (bus.f_valP !== e_valp) begin errors++; $display("FAIL rnd_valp n=%0d got=%0h exp=%0h", n, bus.f_valP, e_valp); end
            checks++;
            if (bus.f_pred_pc !== e_pred) begin errors++; $display("FAIL rnd_pred n=%0d got=%0h exp=%0h", n, bus.f_pred_pc, e_pred); end
            checks++;
            if (bus.f_valid !== e_valid) begin errors++; $display("FAIL rnd_valid n=%0d got=%b exp=%b", n, bus.f_valid, e_valid); end
            checks++;
            if (bus.f_stat !== e_stat) begin errors++; $display("FAIL rnd_stat n=%0d got=%0d exp=%0d", n, bus.f_stat, e_stat); end
            checks++;
            if (bus.halted !== e_halted) begin errors++; $display("FAIL rnd_halted n=%0d got=%b exp=%b", n, bus.halted, e_halted); end
            checks++;
            tick();
            if (bus.pc !== m_pc) begin errors++; $display("FAIL rnd_pc n=%0d got=%0h exp=%0h", n, bus.pc, m_pc); end
            checks++;
            if (bus.fetch_cnt !== m_cnt) begin errors++; $display("FAIL rnd_cnt n=%0d got=%0d exp=%0d", n, bus.fetch_cnt, m_cnt); end
            checks++;
        end
    endtask

    initial begin
        test_reset();
        test_straight_line();
        test_jump();
        test_ret();
        test_stall();
        test_errors();
        test_halt_reset();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
